// File: rtl/seven_seg_signal_gen.sv
// Registered BCD-to-seven-segment encoder for one common-anode digit,
// with lamp-test, blanking and an illegal-code flag around the decode.
module seven_seg_signal_gen #(
  parameter int ACTIVE_LOW = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] BCD,
  input  logic       blank,
  input  logic       lamp_test,
  output logic [6:0] HEX,
  output logic       bcd_err
);

  localparam logic [6:0] SEG_OFF = 7'b1111111;
  localparam logic [6:0] SEG_ON  = 7'b0000000;
  // Everything below is built active-low; this mask flips it for active-high boards.
  localparam logic [6:0] POL_MASK = (ACTIVE_LOW != 0) ? 7'b0000000 : 7'b1111111;

  logic [6:0] digit_seg;
  logic [6:0] next_seg;

  always_comb begin
    digit_seg = SEG_OFF;
    unique case (BCD)
      4'd0:    digit_seg = 7'b1000000;
      4'd1:    digit_seg = 7'b1111001;
      4'd2:    digit_seg = 7'b0100100;
      4'd3:    digit_seg = 7'b0110000;
      4'd4:    digit_seg = 7'b0011001;
      4'd5:    digit_seg = 7'b0010010;
      4'd6:    digit_seg = 7'b0000010;
      4'd7:    digit_seg = 7'b1111000;
      4'd8:    digit_seg = 7'b0000000;
      4'd9:    digit_seg = 7'b0010000;
      default: digit_seg = SEG_OFF;
    endcase
  end

  always_comb begin
    next_seg = digit_seg;
    if (lamp_test) begin
      next_seg = SEG_ON;
    end else if (blank) begin
      next_seg = SEG_OFF;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      HEX     <= SEG_OFF ^ POL_MASK;
      bcd_err <= 1'b0;
    end else begin
      HEX     <= next_seg ^ POL_MASK;
      bcd_err <= (BCD > 4'd9);
    end
  end

endmodule

// File: tb/tb_seven_seg_signal_gen.sv
// Directed bench for seven_seg_signal_gen: active-low and active-high
// instances share stimulus; expected codes are hand-written constants.
module tb_seven_seg_signal_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] bcd = 4'd0;
  logic       blank = 1'b0;
  logic       lamp_test = 1'b0;
  logic [6:0] hex;
  logic       bcd_err;
  logic [6:0] hex_n;
  logic       bcd_err_n;

  int total = 0;
  int passed = 0;

  seven_seg_signal_gen #(.ACTIVE_LOW(1)) dut (
    .clk(clk), .rst(rst), .BCD(bcd), .blank(blank), .lamp_test(lamp_test),
    .HEX(hex), .bcd_err(bcd_err)
  );

  seven_seg_signal_gen #(.ACTIVE_LOW(0)) dut_n (
    .clk(clk), .rst(rst), .BCD(bcd), .blank(blank), .lamp_test(lamp_test),
    .HEX(hex_n), .bcd_err(bcd_err_n)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; bcd = 4'd8; blank = 1'b0; lamp_test = 1'b0;
    step();
    step();
    total++;
    if (hex !== 7'b1111111) $display("FAIL reset_hex got %b want %b", hex, 7'b1111111);
    else passed++;
    total++;
    if (bcd_err !== 1'b0) $display("FAIL reset_err got %b want %b", bcd_err, 1'b0);
    else passed++;
    rst = 1'b0;
    step();
    total++;
    if (hex !== 7'b0000000) $display("FAIL reset_release_hex got %b want %b", hex, 7'b0000000);
    else passed++;
  endtask

  task automatic test_decode_sweep();
    logic [6:0] table_exp [10];
    table_exp[0] = 7'b1000000; table_exp[1] = 7'b1111001;
    table_exp[2] = 7'b0100100; table_exp[3] = 7'b0110000;
    table_exp[4] = 7'b0011001; table_exp[5] = 7'b0010010;
    table_exp[6] = 7'b0000010; table_exp[7] = 7'b1111000;
    table_exp[8] = 7'b0000000; table_exp[9] = 7'b0010000;
    for (int i = 0; i < 10; i++) begin
      bcd = 4'(i);
      step();
      total++;
      if (hex !== table_exp[i]) $display("FAIL decode_%0d got %b want %b", i, hex, table_exp[i]);
      else passed++;
      total++;
      if (bcd_err !== 1'b0) $display("FAIL decode_err_%0d got %b want %b", i, bcd_err, 1'b0);
      else passed++;
    end
  endtask

  task automatic test_illegal();
    for (int i = 10; i < 16; i++) begin
      bcd = 4'(i);
      step();
      total++;
      if (hex !== 7'b1111111) $display("FAIL illegal_hex_%0d got %b want %b", i, hex, 7'b1111111);
      else passed++;
      total++;
      if (bcd_err !== 1'b1) $display("FAIL illegal_err_%0d got %b want %b", i, bcd_err, 1'b1);
      else passed++;
    end
    bcd = 4'd3;
    step();
    total++;
    if (hex !== 7'b0110000) $display("FAIL recover_hex got %b want %b", hex, 7'b0110000);
    else passed++;
    total++;
    if (bcd_err !== 1'b0) $display("FAIL recover_err got %b want %b", bcd_err, 1'b0);
    else passed++;
  endtask

  task automatic test_overrides();
    bcd = 4'd5; blank = 1'b0; lamp_test = 1'b0;
    step();
    total++;
    if (hex !== 7'b0010010) $display("FAIL ovr_plain got %b want %b", hex, 7'b0010010);
    else passed++;
    blank = 1'b1;
    step();
    total++;
    if (hex !== 7'b1111111) $display("FAIL ovr_blank got %b want %b", hex, 7'b1111111);
    else passed++;
    blank = 1'b0; lamp_test = 1'b1;
    step();
    total++;
    if (hex !== 7'b0000000) $display("FAIL ovr_lamp got %b want %b", hex, 7'b0000000);
    else passed++;
    blank = 1'b1; lamp_test = 1'b1;
    step();
    total++;
    if (hex !== 7'b0000000) $display("FAIL ovr_both got %b want %b", hex, 7'b0000000);
    else passed++;
    bcd = 4'd12; blank = 1'b1; lamp_test = 1'b0;
    step();
    total++;
    if (hex !== 7'b1111111) $display("FAIL ovr_blank_illegal_hex got %b want %b", hex, 7'b1111111);
    else passed++;
    total++;
    if (bcd_err !== 1'b1) $display("FAIL ovr_blank_illegal_err got %b want %b", bcd_err, 1'b1);
    else passed++;
    bcd = 4'd13; blank = 1'b0; lamp_test = 1'b1;
    step();
    total++;
    if (bcd_err !== 1'b1) $display("FAIL ovr_lamp_illegal_err got %b want %b", bcd_err, 1'b1);
    else passed++;
    blank = 1'b0; lamp_test = 1'b0;
  endtask

  task automatic test_reset_mid();
    bcd = 4'd6;
    step();
    total++;
    if (hex !== 7'b0000010) $display("FAIL mid_pre got %b want %b", hex, 7'b0000010);
    else passed++;
    bcd = 4'd14; lamp_test = 1'b1; rst = 1'b1;
    step();
    total++;
    if (hex !== 7'b1111111) $display("FAIL mid_rst_hex got %b want %b", hex, 7'b1111111);
    else passed++;
    total++;
    if (bcd_err !== 1'b0) $display("FAIL mid_rst_err got %b want %b", bcd_err, 1'b0);
    else passed++;
    rst = 1'b0; lamp_test = 1'b0; bcd = 4'd2;
    step();
    total++;
    if (hex !== 7'b0100100) $display("FAIL mid_resume got %b want %b", hex, 7'b0100100);
    else passed++;
  endtask

  task automatic test_polarity();
    bcd = 4'd1; blank = 1'b0; lamp_test = 1'b0;
    step();
    total++;
    if (hex_n !== 7'b0000110) $display("FAIL pol_one got %b want %b", hex_n, 7'b0000110);
    else passed++;
    rst = 1'b1;
    step();
    total++;
    if (hex_n !== 7'b0000000) $display("FAIL pol_reset got %b want %b", hex_n, 7'b0000000);
    else passed++;
    rst = 1'b0; lamp_test = 1'b1;
    step();
    total++;
    if (hex_n !== 7'b1111111) $display("FAIL pol_lamp got %b want %b", hex_n, 7'b1111111);
    else passed++;
    lamp_test = 1'b0; blank = 1'b1;
    step();
    total++;
    if (hex_n !== 7'b0000000) $display("FAIL pol_blank got %b want %b", hex_n, 7'b0000000);
    else passed++;
    blank = 1'b0; bcd = 4'd11;
    step();
    total++;
    if (bcd_err_n !== 1'b1) $display("FAIL pol_err got %b want %b", bcd_err_n, 1'b1);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_decode_sweep();
    test_illegal();
    test_overrides();
    test_reset_mid();
    test_polarity();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
